// File: rtl/uart_rx_fifo_receiver.sv
// uart_rx_fifo_receiver: 8N1 UART receiver that queues received bytes in a FWFT FIFO.
//   uart_rx_clk   sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   uart_rx_path  serial line, idle high, asynchronous to uart_rx_clk
//   fifo_rd_req   pop head byte (ignored while fifo_empty)
//   fifo_rd_data  head byte, valid while fifo_empty=0
//   fifo_empty    FIFO holds no bytes
//   fifo_full     FIFO holds 2**FIFO_AW bytes
//   fifo_count    number of bytes stored
//   frame_err     one-cycle pulse: stop bit sampled low
//   overflow      one-cycle pulse: good byte dropped because the FIFO was full
module uart_rx_fifo_receiver #(
   parameter logic [31:0] CLK_FREQ  = 32'd50_000_000,
   parameter logic [31:0] UART_BAUD = 32'd115200,
   parameter int          FIFO_AW   = 4
) (
   input  logic               uart_rx_clk,
   input  logic               reset_n,
   input  logic               uart_rx_path,
   input  logic               fifo_rd_req,
   output logic [7:0]         fifo_rd_data,
   output logic               fifo_empty,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               frame_err,
   output logic               overflow
);
   localparam logic [31:0] BAUD_DIV = CLK_FREQ / UART_BAUD;
   localparam int          CW       = $clog2(BAUD_DIV);
   localparam int          DEPTH    = 2 ** FIFO_AW;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 32'd1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 32'd2 - 32'd1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t             state_q, state_d;
   logic [1:0]         sync_q;
   logic [1:0]         settle_q;
   logic               armed_q, armed_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               empty_q, empty_d, full_q, full_d;
   logic               ferr_q, ferr_d, ovf_q, ovf_d;
   logic               rx_s, push, pop;
   logic [7:0]         mem [DEPTH];

   assign rx_s = sync_q[1];
   assign pop  = fifo_rd_req && !empty_q;

   // After reset the receiver only arms once the synchroniser carries real
   // line samples showing idle-high, so a reset mid-frame cannot turn the
   // remainder of that frame into a false start bit.
   assign armed_d = armed_q || (settle_q[1] && rx_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      push    = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (armed_q && !rx_s) state_d = S_START;
         end
         S_START: if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: if (cnt_q == BAUD_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: if (cnt_q == BAUD_LAST) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_BREAK;
            // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
            push    = rx_s && (!full_q || pop);
            ovf_d   = rx_s && full_q && !pop;
            ferr_d  = !rx_s;
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
      rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
      count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      empty_d  = count_d == '0;
      full_d   = count_d == (FIFO_AW+1)'(DEPTH);
   end

   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= 2'b11;
         settle_q <= 2'b00;
         armed_q  <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], uart_rx_path};
         settle_q <= {settle_q[0], 1'b1};
         armed_q  <= armed_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge uart_rx_clk) begin
      if (push) mem[wr_ptr_q] <= shift_q;
   end

   assign fifo_rd_data = empty_q ? 8'h00 : mem[rd_ptr_q];
   assign fifo_empty   = empty_q;
   assign fifo_full    = full_q;
   assign fifo_count   = count_q;
   assign frame_err    = ferr_q;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// tb_uart_rx_fifo_receiver: randomized and directed checks of the UART receiver against a queue model.
module tb_uart_rx_fifo_receiver;
   localparam int BD    = 16;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] rd_data;
   logic       empty, full, ferr, ovf;
   logic [4:0] count;

   int n_tests = 0, n_fail = 0;
   int ferr_cnt = 0, ovf_cnt = 0, both_cnt = 0;
   int exp_ferr = 0, exp_ovf = 0;
   logic [7:0] q[$];

   uart_rx_fifo_receiver #(
      .CLK_FREQ(32'd1_600_000),
      .UART_BAUD(32'd100_000),
      .FIFO_AW(4)
   ) dut (
      .uart_rx_clk(clk),
      .reset_n(rst_n),
      .uart_rx_path(rx),
      .fifo_rd_req(rd),
      .fifo_rd_data(rd_data),
      .fifo_empty(empty),
      .fifo_full(full),
      .fifo_count(count),
      .frame_err(ferr),
      .overflow(ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ferr) ferr_cnt++;
      if (ovf) ovf_cnt++;
      if (ferr && ovf) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      rx = b;
      repeat (BD) @(negedge clk);
   endtask

   task automatic model_push(input logic [7:0] d);
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ovf++;
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      bit_out(stop);
      if (stop) model_push(d);
      else exp_ferr++;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, count, q.size());
      check({tag, ".empty"}, empty, q.size() == 0);
      check({tag, ".full"}, full, q.size() == DEPTH);
      check({tag, ".data"}, rd_data, q.size() != 0 ? q[0] : 8'h00);
      check({tag, ".ferr"}, ferr_cnt, exp_ferr);
      check({tag, ".ovf"}, ovf_cnt, exp_ovf);
      check({tag, ".both"}, both_cnt, 0);
   endtask

   task automatic pop_chk(input string tag);
      check({tag, ".head"}, rd_data, q.size() != 0 ? q[0] : 8'h00);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      check({tag, ".cnt"}, count, q.size());
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".count"}, count, 0);
      check({tag, ".empty"}, empty, 1);
      check({tag, ".full"}, full, 0);
      check({tag, ".data"}, rd_data, 8'h00);
      check({tag, ".ferr"}, ferr, 0);
      check({tag, ".ovf"}, ovf, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      idle(5);

      send(8'hA5, 1'b1);
      idle(2);
      check_state("a5");
      pop_chk("a5pop");
      check_state("a5_drained");

      rx = 1'b0;
      repeat (5) @(negedge clk);
      idle(40);
      check_state("glitch");

      send(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (20 * BD) @(negedge clk);
      idle(2 * BD);
      send(8'h3C, 1'b1);
      idle(2);
      check_state("break");
      pop_chk("break_pop");

      for (int i = 0; i < 17; i++) begin
         send(8'(i), 1'b1);
         if (i == 15) begin
            idle(2);
            check("full16", full, 1);
         end
      end
      idle(2);
      check_state("ovf");
      for (int i = 0; i < DEPTH; i++) pop_chk("ovf_drain");
      check_state("ovf_drained");

      fork
         begin
            send(8'h55, 1'b1);
            send(8'hAA, 1'b1);
            send(8'hFF, 1'b1);
         end
         begin
            repeat (474) @(posedge clk);
            @(negedge clk);
            check("b2b.count_before", count, 2);
            check("b2b.head_before", rd_data, 8'h55);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            void'(q.pop_front());
         end
      join
      idle(2);
      check_state("b2b");
      pop_chk("b2b_pop1");
      pop_chk("b2b_pop2");

      d = 8'hE7;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(d[i]);
      rx = d[4];
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("midrst");
      q.delete();
      rst_n = 1'b1;
      repeat (BD - 4) @(negedge clk);
      for (int i = 5; i < 8; i++) bit_out(d[i]);
      bit_out(1'b1);
      idle(2 * BD);
      send(8'h81, 1'b1);
      idle(2);
      check_state("midrst_after");
      pop_chk("midrst_pop");

      for (int k = 0; k < 40; k++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            send(d, 1'b0);
            rx = 1'b0;
            repeat ($urandom_range(0, 3 * BD)) @(negedge clk);
            idle(2 * BD);
         end else begin
            send(d, 1'b1);
         end
         check_state("rand");
         repeat ($urandom_range(0, 2)) pop_chk("rand_pop");
         idle($urandom_range(0, 20));
      end
      while (q.size() != 0) pop_chk("rand_drain");
      check_state("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
